// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Bundles the signals between the scan sequencer, the 4:1 mux and the
// snapshot consumer.
//   start, continuous : scan control from the host
//   s1, s0            : mux select lines (channel number)
//   mux_out           : selected mux output fed back to the sequencer
//   snap, snap_valid  : 4-bit snapshot and its valid flag
//   snap_ready        : consumer accepts snap on valid && ready
//   busy, overrun     : status (scan in progress, snapshot overwritten)
// The 'slave' modport is the sequencer; 'master' is the surrounding system.
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
   logic       start;
   logic       continuous;
   logic       s0;
   logic       s1;
   logic       mux_out;
   logic [3:0] snap;
   logic       snap_valid;
   logic       snap_ready;
   logic       busy;
   logic       overrun;

   modport slave (
      input  start, continuous, mux_out, snap_ready,
      output s0, s1, snap, snap_valid, busy, overrun
   );

   modport master (
      output start, continuous, mux_out, snap_ready,
      input  s0, s1, snap, snap_valid, busy, overrun
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Steps the mux select through channels 0..3, spending DWELL cycles on each,
// samples mux_out SETTLE cycles after every select change and packs the four
// samples into a snapshot handed downstream with valid/ready.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mux_scan_ctrl_if.slave (control, mux select/feedback, snapshot,
//          status)
// Parameters:
//   DWELL  : cycles per channel (2..255)
//   SETTLE : cycles after a select change before sampling (1..DWELL-1)
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
   parameter int unsigned DWELL  = 4,
   parameter int unsigned SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst,
   mux_scan_ctrl_if.slave  bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

   logic [0:0] state_q,      state_d;
   logic [1:0] ch_q,         ch_d;
   logic [7:0] cnt_q,        cnt_d;
   logic [3:0] shadow_q,     shadow_d;
   logic [3:0] snap_q,       snap_d;
   logic       snap_valid_q, snap_valid_d;
   logic       overrun_q,    overrun_d;

   logic [3:0] shadow_smp_s;
   logic       sample_s;
   logic       last_s;
   logic       accept_s;

   // Next-state logic for the scan sequencer and snapshot handshake
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      snap_d       = snap_q;
      snap_valid_d = snap_valid_q;
      overrun_d    = overrun_q;

      sample_s = (cnt_q == SETTLE_CNT);
      last_s   = (cnt_q == DWELL_LAST);
      accept_s = snap_valid_q && bus.snap_ready;

      // Shadow including this edge's sample, so a sample that coincides with
      // the end of the dwell (SETTLE == DWELL-1) still reaches the snapshot.
      shadow_smp_s = shadow_q;
      if (sample_s) begin
         shadow_smp_s[ch_q] = bus.mux_out;
      end else begin
         shadow_smp_s = shadow_q;
      end

      if (accept_s) begin
         snap_valid_d = 1'b0;
      end else begin
         snap_valid_d = snap_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d   = ST_SCAN;
               ch_d      = 2'd0;
               cnt_d     = 8'd0;
               shadow_d  = 4'd0;
               overrun_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            shadow_d = shadow_smp_s;
            if (last_s) begin
               cnt_d = 8'd0;
               ch_d  = ch_q + 2'd1;
               if (ch_q == 2'd3) begin
                  snap_d       = shadow_smp_s;
                  snap_valid_d = 1'b1;
                  // Accept on the same edge as a load is not an overrun.
                  if (snap_valid_q && !bus.snap_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     overrun_d = overrun_q;
                  end
                  if (bus.continuous) begin
                     shadow_d = 4'd0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  snap_d = snap_q;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ch_d    = 2'd0;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ch_q         <= 2'd0;
         cnt_q        <= 8'd0;
         shadow_q     <= 4'd0;
         snap_q       <= 4'd0;
         snap_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.s0         = ch_q[0];
   assign bus.s1         = ch_q[1];
   assign bus.snap       = snap_q;
   assign bus.snap_valid = snap_valid_q;
   assign bus.busy       = (state_q == ST_SCAN);
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Directed bench for mux_scan_ctrl (DWELL=4, SETTLE=2) with a behavioural 4:1
// mux that can optionally lag one cycle behind a select change.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

   logic clk;
   logic rst;
   logic in_a, in_b, in_c, in_d;
   logic lag_mode;
   logic [1:0] sel_prev;
   logic [1:0] sel_use;

   int n_tests;
   int n_fail;

   mux_scan_ctrl_if bus_if ();

   mux_scan_ctrl #(.DWELL(4), .SETTLE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Select as seen by the mux model, optionally one cycle stale
   always @(posedge clk) sel_prev <= {bus_if.s1, bus_if.s0};
   assign sel_use = lag_mode ? sel_prev : {bus_if.s1, bus_if.s0};
   assign bus_if.mux_out = (sel_use == 2'd0) ? in_a :
                           (sel_use == 2'd1) ? in_b :
                           (sel_use == 2'd2) ? in_c : in_d;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
   endtask

   task automatic set_mux(input logic [3:0] dcba);
      {in_d, in_c, in_b, in_a} = dcba;
   endtask

   task automatic drain();
      bus_if.snap_ready = 1'b1;
      tick();
      bus_if.snap_ready = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      lag_mode = 1'b0;
      sel_prev = 2'd0;
      bus_if.start = 1'b0;
      bus_if.continuous = 1'b0;
      bus_if.snap_ready = 1'b0;
      set_mux(4'b1101);

      // Reset state
      #1 rst = 1'b1;
      #2;
      check_eq("rst_sel",     {30'd0, bus_if.s1, bus_if.s0}, 32'd0);
      check_eq("rst_snap",    {28'd0, bus_if.snap}, 32'd0);
      check_eq("rst_valid",   {31'd0, bus_if.snap_valid}, 32'd0);
      check_eq("rst_busy",    {31'd0, bus_if.busy}, 32'd0);
      check_eq("rst_overrun", {31'd0, bus_if.overrun}, 32'd0);
      #20 rst = 1'b0;
      tick();

      // Basic scan: a=1 b=0 c=1 d=1 -> snap 1101
      pulse_start();
      check_eq("basic_busy0", {31'd0, bus_if.busy}, 32'd1);
      check_eq("basic_sel0",  {30'd0, bus_if.s1, bus_if.s0}, 32'd0);
      for (int k = 1; k <= 15; k++) begin
         tick();
         check_eq($sformatf("basic_sel_e%0d", k), {30'd0, bus_if.s1, bus_if.s0}, 32'(k / 4));
         check_eq($sformatf("basic_valid_e%0d", k), {31'd0, bus_if.snap_valid}, 32'd0);
         check_eq($sformatf("basic_busy_e%0d", k), {31'd0, bus_if.busy}, 32'd1);
      end
      tick();
      check_eq("basic_valid16",   {31'd0, bus_if.snap_valid}, 32'd1);
      check_eq("basic_snap16",    {28'd0, bus_if.snap}, 32'hD);
      check_eq("basic_busy16",    {31'd0, bus_if.busy}, 32'd0);
      check_eq("basic_overrun16", {31'd0, bus_if.overrun}, 32'd0);
      check_eq("basic_sel16",     {30'd0, bus_if.s1, bus_if.s0}, 32'd0);

      // Handshake: one accepting edge clears valid, data held
      drain();
      check_eq("hs_valid", {31'd0, bus_if.snap_valid}, 32'd0);
      check_eq("hs_snap",  {28'd0, bus_if.snap}, 32'hD);

      // start while busy is ignored
      pulse_start();
      tick();
      tick();
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      check_eq("ign_sel_e3", {30'd0, bus_if.s1, bus_if.s0}, 32'd0);
      tick();
      check_eq("ign_sel_e4", {30'd0, bus_if.s1, bus_if.s0}, 32'd1);
      for (int k = 5; k <= 15; k++) tick();
      check_eq("ign_valid15", {31'd0, bus_if.snap_valid}, 32'd0);
      tick();
      check_eq("ign_valid16", {31'd0, bus_if.snap_valid}, 32'd1);
      check_eq("ign_snap16",  {28'd0, bus_if.snap}, 32'hD);
      drain();

      // Continuous with overrun: all zeros
      set_mux(4'b0000);
      bus_if.continuous = 1'b1;
      pulse_start();
      for (int k = 1; k <= 16; k++) tick();
      check_eq("cont_snap16",    {28'd0, bus_if.snap}, 32'h0);
      check_eq("cont_valid16",   {31'd0, bus_if.snap_valid}, 32'd1);
      check_eq("cont_overrun16", {31'd0, bus_if.overrun}, 32'd0);
      check_eq("cont_busy16",    {31'd0, bus_if.busy}, 32'd1);
      for (int k = 17; k <= 31; k++) tick();
      check_eq("cont_overrun31", {31'd0, bus_if.overrun}, 32'd0);
      tick();
      check_eq("cont_overrun32", {31'd0, bus_if.overrun}, 32'd1);
      check_eq("cont_busy32",    {31'd0, bus_if.busy}, 32'd1);
      bus_if.continuous = 1'b0;
      for (int k = 33; k <= 48; k++) tick();
      check_eq("cont_stop_busy", {31'd0, bus_if.busy}, 32'd0);
      check_eq("cont_overrun_sticky", {31'd0, bus_if.overrun}, 32'd1);
      drain();

      // Simultaneous accept and load on edge 32
      set_mux(4'b0011);
      bus_if.continuous = 1'b1;
      pulse_start();
      check_eq("sim_overrun_clr", {31'd0, bus_if.overrun}, 32'd0);
      for (int k = 1; k <= 16; k++) tick();
      check_eq("sim_snap16", {28'd0, bus_if.snap}, 32'h3);
      set_mux(4'b0110);
      for (int k = 17; k <= 31; k++) tick();
      bus_if.snap_ready = 1'b1;
      tick();
      bus_if.snap_ready = 1'b0;
      check_eq("sim_valid32",   {31'd0, bus_if.snap_valid}, 32'd1);
      check_eq("sim_snap32",    {28'd0, bus_if.snap}, 32'h6);
      check_eq("sim_overrun32", {31'd0, bus_if.overrun}, 32'd0);
      bus_if.continuous = 1'b0;
      for (int k = 33; k <= 48; k++) tick();
      check_eq("sim_idle", {31'd0, bus_if.busy}, 32'd0);
      drain();

      // Settle timing: mux lags one cycle after a select change
      lag_mode = 1'b1;
      set_mux(4'b1010);
      pulse_start();
      for (int k = 1; k <= 16; k++) tick();
      check_eq("settle_valid", {31'd0, bus_if.snap_valid}, 32'd1);
      check_eq("settle_snap",  {28'd0, bus_if.snap}, 32'hA);
      lag_mode = 1'b0;

      // Reset mid-scan at edge 6 (snap/valid still hold the previous result)
      set_mux(4'b0111);
      pulse_start();
      for (int k = 1; k <= 5; k++) tick();
      check_eq("mid_pre_sel", {30'd0, bus_if.s1, bus_if.s0}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("mid_sel",     {30'd0, bus_if.s1, bus_if.s0}, 32'd0);
      check_eq("mid_snap",    {28'd0, bus_if.snap}, 32'd0);
      check_eq("mid_valid",   {31'd0, bus_if.snap_valid}, 32'd0);
      check_eq("mid_busy",    {31'd0, bus_if.busy}, 32'd0);
      check_eq("mid_overrun", {31'd0, bus_if.overrun}, 32'd0);
      #12 rst = 1'b0;
      tick();
      pulse_start();
      for (int k = 1; k <= 15; k++) tick();
      check_eq("fresh_valid15", {31'd0, bus_if.snap_valid}, 32'd0);
      tick();
      check_eq("fresh_valid16", {31'd0, bus_if.snap_valid}, 32'd1);
      check_eq("fresh_snap16",  {28'd0, bus_if.snap}, 32'h7);
      check_eq("fresh_busy16",  {31'd0, bus_if.busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
